seven_segment_button_cond: RTL and testbench

//   Input-side conditioner for the 7-segment animation core's push-buttons
//   (incAni, decAni, incSpeed, decSpeed on ui_in[3:0]). Synchronizes and

---
 rtl/seven_segment_button_cond_if.sv | 28 ++
 rtl/seven_segment_button_cond.sv | 164 ++++++++++++++++
 tb/tb_seven_segment_button_cond.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_button_cond_if.sv
// Event handshake between the button conditioner and the animation controller.
//   evt_valid   producer -> consumer   a press event is pending
//   evt_idx     producer -> consumer   index of the lowest pending event
//   evt_ready   consumer -> producer   consumer takes evt_idx this cycle
//   evt_overrun producer -> consumer   one-cycle pulse: a press was dropped
// master = conditioner side, slave = consumer side.
interface seven_segment_button_cond_if #(
   parameter int IDX_W = 2
);
   logic             evt_valid;
   logic [IDX_W-1:0] evt_idx;
   logic             evt_ready;
   logic             evt_overrun;

   modport master (
      output evt_valid,
      output evt_idx,
      output evt_overrun,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_idx,
      input  evt_overrun,
      output evt_ready
   );
endinterface

// File: rtl/seven_segment_button_cond.sv
// Push-button conditioner for the 7-segment animation core.
// Synchronizes and debounces the raw button pins and turns debounced presses
// into a buffered event stream, one event per physical press.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   ena        block enable; when low the debouncers hold and no new events
//              are created, but already pending events can still be taken
//   btn_raw    asynchronous raw pins, 1 = pressed
//   btn_level  debounced button level
//   btn_press  one-cycle pulse on a debounced press (real or auto-repeat)
//   evt        event handshake (master side), see seven_segment_button_cond_if
//
// Build option
//   AUTO_REPEAT_EN  when defined, a held button produces synthetic presses
//                   REPEAT_DELAY cycles after the press, then every
//                   REPEAT_PERIOD cycles, until release or ena drops.
module seven_segment_button_cond #(
   parameter int N_BTN           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 5000000,
   parameter int REPEAT_PERIOD   = 2000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic [N_BTN-1:0]          btn_raw,
   output logic [N_BTN-1:0]          btn_level,
   output logic [N_BTN-1:0]          btn_press,
   seven_segment_button_cond_if.master evt
);

   localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync_q [SYNC_STAGES];
   logic [N_BTN-1:0] s;
   logic [N_BTN-1:0] toggle;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] press_set;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] clr_mask;
   logic [N_BTN-1:0] drop;
   logic [IDX_W-1:0] idx_sel;

   // Plain flop chain: nothing may sit between the pin and the last stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= btn_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Per-button debounce: the count only survives while the synchronized
   // input keeps disagreeing with the accepted level.
   for (genvar i = 0; i < N_BTN; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
         end else if (!ena || (s[i] == btn_level[i]) || (cnt == CNT_LAST)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      assign toggle[i] = ena && (s[i] != btn_level[i]) && (cnt == CNT_LAST);
   end

   assign rise = toggle & ~btn_level;

   always_ff @(posedge clk) begin
      if (rst) btn_level <= '0;
      else     btn_level <= btn_level ^ toggle;
   end

`ifdef AUTO_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

   logic [N_BTN-1:0] fall;
   logic [N_BTN-1:0] rep;

   assign fall = toggle & btn_level;

   // Down-counter per button, loaded on the real press. The armed bit keeps a
   // button that was held across an ena drop from repeating until re-pressed.
   for (genvar i = 0; i < N_BTN; i++) begin : g_rep
      logic [HOLD_W-1:0] hcnt;
      logic              armed;

      assign rep[i] = armed && ena && btn_level[i] && !fall[i] && (hcnt == '0);

      always_ff @(posedge clk) begin
         if (rst) begin
            hcnt  <= '0;
            armed <= 1'b0;
         end else if (rise[i]) begin
            hcnt  <= HOLD_W'(REPEAT_DELAY - 1);
            armed <= 1'b1;
         end else if (!ena || !btn_level[i] || fall[i]) begin
            hcnt  <= '0;
            armed <= 1'b0;
         end else if (armed) begin
            if (hcnt == '0) hcnt <= HOLD_W'(REPEAT_PERIOD - 1);
            else            hcnt <= hcnt - HOLD_W'(1);
         end
      end
   end

   assign press_set = rise | rep;
`else
   // Repeat timing is unused in this build; the parameters stay so that both
   // builds share one instantiation. This branch only exists to reference them.
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_bad
   end

   assign press_set = rise;
`endif

   always_ff @(posedge clk) begin
      if (rst) btn_press <= '0;
      else     btn_press <= press_set;
   end

   always_comb begin
      idx_sel = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pending[i]) idx_sel = IDX_W'(i);
      end
   end

   assign evt.evt_valid = |pending;
   assign evt.evt_idx   = idx_sel;

   always_comb begin
      clr_mask = '0;
      if (evt.evt_valid && evt.evt_ready) clr_mask = N_BTN'(1) << idx_sel;
   end

   // A press landing on the bit being transferred this cycle is kept as a new
   // event; only a press onto a bit that stays pending is lost.
   assign drop = btn_press & pending & ~clr_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending         <= '0;
         evt.evt_overrun <= 1'b0;
      end else begin
         pending         <= (pending & ~clr_mask) | btn_press;
         evt.evt_overrun <= |drop;
      end
   end

endmodule

// File: tb/tb_seven_segment_button_cond.sv
module tb_seven_segment_button_cond;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;

   seven_segment_button_cond_if #(.IDX_W(2)) evt ();

   seven_segment_button_cond #(
      .N_BTN           (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .evt       (evt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int press_cnt = 0;
   int ov_cnt    = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_level(input int i, input logic val, output int n);
      n = 0;
      while (btn_level[i] !== val && n < 40) begin
         tick(1);
         n++;
      end
   endtask

   // Monitor: every accepted event must match the next expected index.
   always @(negedge clk) begin
      if (!rst) begin
         if (evt.evt_valid && evt.evt_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_evt: got idx %0d expected none at %0t", evt.evt_idx, $time);
            end else begin
               check("evt_idx", int'(evt.evt_idx), exp_q.pop_front());
            end
         end
         press_cnt += $countones(btn_press);
         ov_cnt    += int'(evt.evt_overrun);
      end
   end

   initial begin
      int n;
      int p0;
      int o0;
      rst           = 1'b1;
      ena           = 1'b1;
      btn_raw       = '0;
      evt.evt_ready = 1'b1;
      tick(3);
      check("rst_level", int'(btn_level), 0);
      check("rst_press", int'(btn_press), 0);
      check("rst_valid", int'(evt.evt_valid), 0);
      check("rst_overrun", int'(evt.evt_overrun), 0);
      rst = 1'b0;
      tick(1);

      // single press: latency, one pulse, one event
      btn_raw[0] = 1'b1;
      exp_q.push_back(0);
      wait_level(0, 1'b1, n);
      check("t1_latency", n, 6);
      check("t1_press_hi", int'(btn_press), 1);
      tick(1);
      check("t1_press_lo", int'(btn_press), 0);
      tick(12);
      btn_raw[0] = 1'b0;
      tick(15);
      check("t1_level_rel", int'(btn_level), 0);
      check("t1_queue", exp_q.size(), 0);

      // glitches shorter than the debounce window
      p0 = press_cnt;
      btn_raw[2] = 1'b1; tick(3);
      btn_raw[2] = 1'b0; tick(6);
      btn_raw[2] = 1'b1; tick(3);
      btn_raw[2] = 1'b0; tick(1);
      btn_raw[2] = 1'b1; tick(2);
      btn_raw[2] = 1'b0; tick(10);
      check("t2_level", int'(btn_level), 0);
      check("t2_presses", press_cnt - p0, 0);

      // simultaneous presses drain lowest index first
      btn_raw[1] = 1'b1;
      btn_raw[3] = 1'b1;
      exp_q.push_back(1);
      exp_q.push_back(3);
      tick(12);
      check("t3_queue", exp_q.size(), 0);
      btn_raw = '0;
      tick(12);

      // second press while first still pending is dropped
      evt.evt_ready = 1'b0;
      o0 = ov_cnt;
      btn_raw[2] = 1'b1; exp_q.push_back(2); tick(10);
      btn_raw[2] = 1'b0; tick(10);
      btn_raw[2] = 1'b1; tick(10);
      btn_raw[2] = 1'b0; tick(10);
      check("t4_overruns", ov_cnt - o0, 1);
      check("t4_valid", int'(evt.evt_valid), 1);
      check("t4_idx", int'(evt.evt_idx), 2);
      evt.evt_ready = 1'b1;
      tick(3);
      check("t4_queue", exp_q.size(), 0);
      check("t4_valid_after", int'(evt.evt_valid), 0);

      // reset mid-debounce with an event pending
      evt.evt_ready = 1'b0;
      btn_raw[3] = 1'b1; tick(10);
      btn_raw[3] = 1'b0;
      check("t5_pending", int'(evt.evt_valid), 1);
      tick(10);
      btn_raw[0] = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t5_valid", int'(evt.evt_valid), 0);
      check("t5_level", int'(btn_level), 0);
      check("t5_press", int'(btn_press), 0);
      check("t5_overrun", int'(evt.evt_overrun), 0);
      evt.evt_ready = 1'b1;
      exp_q.push_back(0);
      wait_level(0, 1'b1, n);
      check("t5_latency", n, 6);
      tick(10);
      btn_raw[0] = 1'b0;
      tick(15);
      check("t5_queue", exp_q.size(), 0);

      // ena low: debouncer frozen, pending still drains
      evt.evt_ready = 1'b0;
      btn_raw[1] = 1'b1; exp_q.push_back(1); tick(12);
      btn_raw[1] = 1'b0; tick(10);
      ena = 1'b0;
      p0 = press_cnt;
      btn_raw[2] = 1'b1; tick(12);
      check("t6_level", int'(btn_level), 0);
      check("t6_presses", press_cnt - p0, 0);
      evt.evt_ready = 1'b1;
      tick(2);
      check("t6_queue", exp_q.size(), 0);
      btn_raw[2] = 1'b0; tick(4);
      ena = 1'b1;
      tick(10);
      check("t6_level_after", int'(btn_level), 0);

`ifdef AUTO_REPEAT_EN
      // auto-repeat: presses at +0, +8, then every 4 until release
      btn_raw[0] = 1'b1;
      exp_q.push_back(0);
      wait_level(0, 1'b1, n);
      check("t7_latency", n, 6);
      for (int off = 0; off < 80; off++) begin
         bit exp_p;
         if (off == 30) btn_raw[0] = 1'b0;
         if (btn_level[0] == 1'b0) break;
         exp_p = (off == 0) || (off >= 8 && ((off - 8) % 4) == 0);
         check("t7_press", int'(btn_press[0]), int'(exp_p));
         if (exp_p && off > 0) exp_q.push_back(0);
         tick(1);
      end
      p0 = press_cnt;
      tick(20);
      check("t7_after_release", press_cnt - p0, 0);
      check("t7_queue", exp_q.size(), 0);
`endif

      check("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
